// File: rtl/alu_seq_n.sv
// WIDTH-bit ALU: logic/add/sub complete in one clock, unsigned shift-add MUL takes WIDTH clocks.
// Valid/ready handshake; o_ready is low only while a multiply is iterating.
module alu_seq_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             o_valid,
  output logic             flag_c,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_v
);

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_XNOR = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]   mcand, mcand_nxt;
  logic [WIDTH-1:0]   mplier, mplier_nxt;
  logic [2*WIDTH-1:0] prod, prod_nxt;

  logic [WIDTH-1:0]   result_nxt, result_hi_nxt;
  logic               valid_nxt, c_nxt, n_nxt, z_nxt, v_nxt;

  logic [WIDTH-1:0]   b_eff;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;

  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] step_prod;

  assign o_ready = (state == IDLE);

  // Single-cycle ALU; subtraction is a + ~b + 1 so carry means "no borrow".
  always_comb begin
    b_eff   = (op == OP_SUB) ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    alu_res = ~a;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_NOT:  alu_res = ~a;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_XNOR: alu_res = ~(a ^ b);
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      default: alu_res = ~a;
    endcase
  end

  // One shift-add iteration: conditional add into the upper half, then shift right.
  always_comb begin
    step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    step_prod = {step_sum, prod[WIDTH-1:1]};
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    mcand_nxt     = mcand;
    mplier_nxt    = mplier;
    prod_nxt      = prod;
    result_nxt    = result;
    result_hi_nxt = result_hi;
    c_nxt         = flag_c;
    n_nxt         = flag_n;
    z_nxt         = flag_z;
    v_nxt         = flag_v;
    valid_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (i_valid) begin
          // An unknown op fails this test and falls through to the NOT path.
          if (op == OP_MUL) begin
            mcand_nxt  = a;
            mplier_nxt = b;
            prod_nxt   = '0;
            cnt_nxt    = CNT_W'(WIDTH);
            state_nxt  = MUL;
          end else begin
            result_nxt    = alu_res;
            result_hi_nxt = '0;
            c_nxt         = alu_c;
            n_nxt         = alu_res[WIDTH-1];
            z_nxt         = (alu_res == '0);
            v_nxt         = alu_v;
            valid_nxt     = 1'b1;
          end
        end
      end
      MUL: begin
        prod_nxt   = step_prod;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt     = IDLE;
          result_nxt    = step_prod[WIDTH-1:0];
          result_hi_nxt = step_prod[2*WIDTH-1:WIDTH];
          c_nxt         = |step_prod[2*WIDTH-1:WIDTH];
          n_nxt         = step_prod[2*WIDTH-1];
          z_nxt         = (step_prod == '0);
          v_nxt         = 1'b0;
          valid_nxt     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      result    <= '0;
      result_hi <= '0;
      o_valid   <= 1'b0;
      flag_c    <= 1'b0;
      flag_n    <= 1'b0;
      flag_z    <= 1'b0;
      flag_v    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      mcand     <= mcand_nxt;
      mplier    <= mplier_nxt;
      prod      <= prod_nxt;
      result    <= result_nxt;
      result_hi <= result_hi_nxt;
      o_valid   <= valid_nxt;
      flag_c    <= c_nxt;
      flag_n    <= n_nxt;
      flag_z    <= z_nxt;
      flag_v    <= v_nxt;
    end
  end

endmodule
